// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: stalls the PC, runs a req/ready memory
// handshake with byte lanes, and aligns/extends returned load data.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned AW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [4:0]    dec_memi,
   input  logic          dec_enpc,
   input  logic          dec_rfwe,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic          enpc,
   output logic          rfwe,
   output logic [31:0]   load_data,
   output logic          mem_req,
   input  logic          mem_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic          mem_rvalid,
   input  logic [31:0]   mem_rdata,
   output logic          err,
   output logic          busy
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    f3_q;
   logic          we_q;
   logic          err_q;
   logic [CW-1:0] cnt;

   logic          access_c, misal_c, hs_c, tmo_c;
   logic [1:0]    off;
   logic [31:0]   shifted_c, ld_ext_c;

   assign access_c = dec_memi[4] | dec_memi[3];
   assign misal_c  = ((dec_memi[1:0] == 2'b01) && addr[0]) ||
                     ((dec_memi[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   assign hs_c     = (state == S_REQ) && mem_ready;
   assign tmo_c    = ((state == S_REQ) || (state == S_WAIT)) && (cnt == CW'(TIMEOUT - 1));
   assign off      = addr_q[1:0];

   assign mem_req   = (state == S_REQ);
   assign busy      = (state != S_IDLE);
   assign err       = (state == S_DONE) && err_q;
   assign mem_we    = we_q;
   assign mem_addr  = {addr_q[AW-1:2], 2'b00};
   assign mem_wdata = wdata_q << {off, 3'b000};

   always_comb begin
      mem_be = 4'b1111;
      case (f3_q[1:0])
         2'b00:   mem_be = 4'b0001 << off;
         2'b01:   mem_be = 4'b0011 << off;
         default: mem_be = 4'b1111;
      endcase
   end

   // Load alignment and extension from the addressed lane
   always_comb begin
      shifted_c = mem_rdata >> {off, 3'b000};
      ld_ext_c  = shifted_c;
      case (f3_q)
         3'b000:  ld_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         3'b001:  ld_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  ld_ext_c = {24'b0, shifted_c[7:0]};
         3'b101:  ld_ext_c = {16'b0, shifted_c[15:0]};
         default: ld_ext_c = shifted_c;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state plus PC / register-file gating
   always_comb begin
      state_nxt = state;
      enpc      = 1'b0;
      rfwe      = 1'b0;
      case (state)
         S_IDLE: begin
            if (access_c) begin
               state_nxt = misal_c ? S_DONE : S_REQ;
            end else begin
               enpc = dec_enpc;
               rfwe = dec_rfwe;
            end
         end
         S_REQ: begin
            if (hs_c)       state_nxt = (we_q || mem_rvalid) ? S_DONE : S_WAIT;
            else if (tmo_c) state_nxt = S_DONE;
         end
         S_WAIT: begin
            if (mem_rvalid || tmo_c) state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
            enpc      = 1'b1;
            rfwe      = ~we_q & ~err_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         f3_q      <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         cnt       <= '0;
         load_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (access_c) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  f3_q    <= dec_memi[2:0];
                  we_q    <= ~dec_memi[4];
                  err_q   <= misal_c;
                  cnt     <= '0;
               end
            end
            S_REQ: begin
               cnt <= cnt + CW'(1);
               if (hs_c) begin
                  if (!we_q && mem_rvalid) load_data <= ld_ext_c;
               end else if (tmo_c) begin
                  err_q     <= 1'b1;
                  load_data <= '0;
               end
            end
            S_WAIT: begin
               cnt <= cnt + CW'(1);
               if (mem_rvalid) begin
                  load_data <= ld_ext_c;
               end else if (tmo_c) begin
                  err_q     <= 1'b1;
                  load_data <= '0;
               end
            end
            default: err_q <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and random load/store timelines checked
// against a spec-level reference model of byte lanes, extension and timing.
module tb_lsu_ctrl;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  dec_memi;
   logic        dec_enpc, dec_rfwe;
   logic [31:0] addr, wdata;
   logic        enpc, rfwe;
   logic [31:0] load_data;
   logic        mem_req, mem_ready, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        err, busy;

   int tests = 0;
   int fails = 0;
   logic [31:0] ld_model = 32'h0;

   lsu_ctrl #(.TIMEOUT(TMO), .AW(32)) dut (
      .clk(clk), .rst(rst), .dec_memi(dec_memi), .dec_enpc(dec_enpc),
      .dec_rfwe(dec_rfwe), .addr(addr), .wdata(wdata), .enpc(enpc),
      .rfwe(rfwe), .load_data(load_data), .mem_req(mem_req),
      .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference: access size in bytes from func3
   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
      int o = int'(a[1:0]);
      if (f3[1:0] == 2'b01) return (o % 2) != 0;
      if (f3[1:0] == 2'b10) return o != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      int o  = int'(a[1:0]);
      int m;
      if (sz == 4) return 4'hF;
      m = ((1 << sz) - 1) * (1 << o);
      return 4'(m);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      longint v = longint'(rd >> (8 * int'(a[1:0])));
      case (f3)
         3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'b100: v = v % 256;
         3'b101: v = v % 65536;
         default: ;
      endcase
      return 32'(v);
   endfunction

   task automatic idle_check(input string tag);
      @(negedge clk);
      dec_memi = 5'b0; dec_enpc = 1'($urandom); dec_rfwe = 1'($urandom);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      #1;
      chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
      chk({tag, "_idle_enpc"}, 32'(enpc), 32'(dec_enpc));
      chk({tag, "_idle_rfwe"}, 32'(rfwe), 32'(dec_rfwe));
      chk({tag, "_idle_err"}, 32'(err), 32'(0));
      chk({tag, "_idle_ld"}, load_data, ld_model);
   endtask

   task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
      @(negedge clk);
      dec_memi = {ld, ld ? 1'($urandom) : 1'b1, f3};
      addr = a; wdata = wd; dec_enpc = 1'b1; dec_rfwe = ld;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      #1;
      chk({tag, "_iss_enpc"}, 32'(enpc), 32'(0));
      chk({tag, "_iss_rfwe"}, 32'(rfwe), 32'(0));
      chk({tag, "_iss_busy"}, 32'(busy), 32'(0));
      chk({tag, "_iss_req"}, 32'(mem_req), 32'(0));
   endtask

   // One access: ready after d stall cycles, load data r cycles after handshake
   task automatic run_txn(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int d, input int r, input string tag);
      bit mis = is_misal(f3, a);
      issue(ld, f3, a, wd, tag);
      if (!mis) begin
         for (int k = 0; k <= d; k++) begin
            @(negedge clk);
            mem_ready  = (k == d);
            mem_rvalid = ld && (r == 0) && (k == d);
            mem_rdata  = mem_rvalid ? rd : $urandom;
            #1;
            chk({tag, "_req"}, 32'(mem_req), 32'(1));
            chk({tag, "_req_enpc"}, 32'(enpc), 32'(0));
            chk({tag, "_req_addr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, "_req_be"}, 32'(mem_be), 32'(ref_be(f3, a)));
            chk({tag, "_req_we"}, 32'(mem_we), 32'(!ld));
            if (!ld) chk({tag, "_req_wdata"}, mem_wdata, wd << (8 * int'(a[1:0])));
         end
         if (ld) begin
            for (int k = 1; k <= r; k++) begin
               @(negedge clk);
               mem_ready  = 1'($urandom);
               mem_rvalid = (k == r);
               mem_rdata  = mem_rvalid ? rd : $urandom;
               #1;
               chk({tag, "_wait_req"}, 32'(mem_req), 32'(0));
               chk({tag, "_wait_busy"}, 32'(busy), 32'(1));
               chk({tag, "_wait_enpc"}, 32'(enpc), 32'(0));
            end
            ld_model = ref_load(f3, a, rd);
         end
      end
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      #1;
      chk({tag, "_done_enpc"}, 32'(enpc), 32'(1));
      chk({tag, "_done_rfwe"}, 32'(rfwe), 32'(ld && !mis));
      chk({tag, "_done_err"}, 32'(err), 32'(mis));
      chk({tag, "_done_busy"}, 32'(busy), 32'(1));
      chk({tag, "_done_req"}, 32'(mem_req), 32'(0));
      chk({tag, "_done_ld"}, load_data, ld_model);
      idle_check(tag);
   endtask

   // Timeout: ready at cycle ready_at (negative = never), read data never returns
   task automatic run_tmo(input logic ld, input int ready_at, input string tag);
      issue(ld, 3'b010, 32'h200, $urandom, tag);
      for (int k = 0; k < int'(TMO); k++) begin
         @(negedge clk);
         mem_ready = (k == ready_at); mem_rvalid = 1'b0; mem_rdata = $urandom;
         #1;
         chk({tag, "_tmo_req"}, 32'(mem_req), 32'(ready_at < 0 || k <= ready_at));
         chk({tag, "_tmo_err"}, 32'(err), 32'(0));
         chk({tag, "_tmo_busy"}, 32'(busy), 32'(1));
      end
      ld_model = 32'h0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk({tag, "_tmo_done_err"}, 32'(err), 32'(1));
      chk({tag, "_tmo_done_rfwe"}, 32'(rfwe), 32'(0));
      chk({tag, "_tmo_done_enpc"}, 32'(enpc), 32'(1));
      chk({tag, "_tmo_done_req"}, 32'(mem_req), 32'(0));
      chk({tag, "_tmo_done_ld"}, load_data, 32'h0);
      idle_check(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; dec_memi = 5'b0; dec_enpc = 1'b0; dec_rfwe = 1'b0;
      addr = '0; wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_req", 32'(mem_req), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_ld", load_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // ALU instruction passes through untouched
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dec_memi = 5'b0; dec_enpc = 1'b1; dec_rfwe = 1'b1;
         #1;
         chk("add_enpc", 32'(enpc), 32'(1));
         chk("add_rfwe", 32'(rfwe), 32'(1));
         chk("add_req", 32'(mem_req), 32'(0));
         chk("add_busy", 32'(busy), 32'(0));
      end

      run_txn(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 0, "sw");
      run_txn(1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 2, "lb");
      chk("lb_value", ld_model, 32'hFFFF_FF80);
      run_txn(1'b1, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1, 0, "lhu");
      chk("lhu_value", ld_model, 32'h0000_8001);
      run_txn(1'b0, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 0, 0, "sb");
      run_txn(1'b1, 3'b010, 32'h102, 32'h0, 32'h1234_5678, 0, 0, "lw_mis");

      run_tmo(1'b1, -1, "tmo_req");
      run_tmo(1'b1, 0, "tmo_wait");
      run_tmo(1'b0, -1, "tmo_st");

      // Reset while waiting for read data; a late rvalid must be ignored
      run_txn(1'b1, 3'b010, 32'h300, 32'h0, 32'h5555_AAAA, 0, 0, "pre_rst");
      issue(1'b1, 3'b010, 32'h304, 32'h0, "rst_wait");
      @(negedge clk);
      mem_ready = 1'b1; mem_rvalid = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0; rst = 1'b1;
      #1;
      chk("rst_wait_state", 32'(mem_req), 32'(0));
      @(negedge clk);
      rst = 1'b0; dec_memi = 5'b0; dec_enpc = 1'b1; dec_rfwe = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      ld_model = 32'h0;
      #1;
      chk("rst_busy_after", 32'(busy), 32'(0));
      chk("rst_req_after", 32'(mem_req), 32'(0));
      chk("rst_ld_after", load_data, 32'h0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("late_rvalid_ld", load_data, 32'h0);
      chk("late_rvalid_busy", 32'(busy), 32'(0));

      // Random accesses with latencies kept inside the timeout window
      for (int i = 0; i < 40; i++) begin
         logic       ld;
         logic [2:0] f3;
         ld = 1'($urandom);
         f3 = ld ? 3'($urandom) : {1'b0, 2'($urandom)};
         run_txn(ld, f3, $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
